// File: rtl/uart_transmitter_if.sv
// Byte handshake between the UART control logic and the serial transmitter.
// The control logic is the master; the transmitter is the slave.
`timescale 1ns/1ps
interface uart_transmitter_if;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;

  modport master (
    output DataIn,
    output DataInValid,
    input  DataInReady
  );

  modport slave (
    input  DataIn,
    input  DataInValid,
    output DataInReady
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter: accepts a byte on a ready/valid handshake and
// shifts it out LSB first with a registered, glitch-free SOut.
`timescale 1ns/1ps
module uart_transmitter #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic             Clock,
  input  logic             Reset_n,
  uart_transmitter_if.slave bus,
  output logic             SOut
);

  localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
  localparam int ClockCounterWidth = $clog2(SymbolEdgeTime);
  localparam int CW                = ClockCounterWidth;
  localparam logic [CW-1:0] LastTick = CW'(SymbolEdgeTime - 1);

  if (SymbolEdgeTime < 2) begin : g_rate_check
    $error("SymbolEdgeTime must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tick;

  assign tick            = (clk_cnt == LastTick);
  assign bus.DataInReady = (state == IDLE);

  // SOut is loaded with the value of the state being entered, so each
  // symbol starts on the same edge as its state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      SOut    <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          SOut    <= 1'b1;
          if (bus.DataInValid) begin
            shift <= bus.DataIn;
            state <= START;
            SOut  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            SOut    <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              SOut  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              SOut    <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            state   <= IDLE;
            SOut    <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          SOut  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized self-checking bench for uart_transmitter against a
// bit-timing model of the 8N1 frame and a serial receiver model.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int S  = 10;
  localparam int FR = 10 * S;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b1;
  logic SOut;

  uart_transmitter_if bus ();

  uart_transmitter #(
    .ClockFreq(1000),
    .BaudRate (100)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus.slave),
    .SOut   (SOut)
  );

  always #5 Clock = ~Clock;

  int   tests = 0;
  int   fails = 0;
  logic smp [0:FR];
  logic rdy [0:FR];
  time  t_acc;

  // Expected line level i cycles after the accept edge.
  function automatic logic model_sout(input logic [7:0] d, input int i);
    int b;
    b = i / S;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  // Receiver: sample each data bit at its centre.
  function automatic logic [7:0] rx_decode();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = smp[(k+1)*S + S/2];
    return r;
  endfunction

  task automatic start_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3*FR; n++) begin
      if (bus.DataInReady === 1'b1) begin
        @(posedge Clock);
        t_acc = $time;
        ok = 1'b1;
        return;
      end
      @(negedge Clock);
    end
    tests++;
    fails++;
    $display("FAIL start_frame: DataInReady=%b, required 1", bus.DataInReady);
  endtask

  task automatic capture(input int ev_at, input logic [7:0] ev_data,
                         input logic ev_valid);
    for (int i = 0; i <= FR; i++) begin
      @(negedge Clock);
      smp[i] = SOut;
      rdy[i] = bus.DataInReady;
      if (i == ev_at) begin
        bus.DataIn      = ev_data;
        bus.DataInValid = ev_valid;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int bad;
    bus.DataIn      = 8'hE7;
    bus.DataInValid = 1'b1;
    #1 Reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      tests++;
      if ({SOut, bus.DataInReady} !== 2'b11) begin
        fails++;
        $display("FAIL reset_hold: SOut,rdy=%b%b, required 11",
                 SOut, bus.DataInReady);
      end
    end
    Reset_n = 1'b1;
    start_frame(ok);
    if (!ok) return;
    capture(0, 8'hE7, 1'b0);
    bad = -1;
    for (int i = 0; i <= FR; i++)
      if (smp[i] !== model_sout(8'hE7, i) || rdy[i] !== (i == FR)) begin
        bad = i;
        break;
      end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL reset_frame: idx %0d SOut=%b rdy=%b, required %b %b",
               bad, smp[bad], rdy[bad], model_sout(8'hE7, bad), bad == FR);
    end
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    @(negedge Clock);
    bus.DataIn      = 8'hA5;
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    capture(0, 8'hA5, 1'b0);
    tests++;
    if (rdy[0] !== 1'b0) begin
      fails++;
      $display("FAIL a5_ready_drop: rdy=%b, required 0", rdy[0]);
    end
    bad = -1;
    for (int i = 0; i < FR; i++)
      if (smp[i] !== model_sout(8'hA5, i)) begin
        bad = i;
        break;
      end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL a5_bits: idx %0d SOut=%b, required %b",
               bad, smp[bad], model_sout(8'hA5, bad));
    end
    tests++;
    if ({rdy[FR-1], rdy[FR]} !== 2'b01) begin
      fails++;
      $display("FAIL a5_ready_100: rdy99,rdy100=%b%b, required 01",
               rdy[FR-1], rdy[FR]);
    end
    tests++;
    if (rx_decode() !== 8'hA5) begin
      fails++;
      $display("FAIL a5_rx: got %h, required a5", rx_decode());
    end
  endtask

  task automatic test_back_to_back();
    bit  ok;
    time t1;
    @(negedge Clock);
    bus.DataIn      = 8'h00;
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    t1 = t_acc;
    capture(0, 8'hFF, 1'b1);
    tests++;
    if (rx_decode() !== 8'h00 || smp[0] !== 1'b0 || smp[FR] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: rx=%h start=%b idle=%b, required 00 0 1",
               rx_decode(), smp[0], smp[FR]);
    end
    start_frame(ok);
    if (!ok) return;
    tests++;
    if (t_acc - t1 !== 64'd1010) begin
      fails++;
      $display("FAIL b2b_period: got %0t, required 1010", t_acc - t1);
    end
    capture(0, 8'hFF, 1'b0);
    tests++;
    if (rx_decode() !== 8'hFF || smp[0] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: rx=%h start=%b, required ff 0",
               rx_decode(), smp[0]);
    end
  endtask

  task automatic test_data_change();
    bit ok;
    int bad;
    @(negedge Clock);
    bus.DataIn      = 8'h81;
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    capture(45, 8'h3C, 1'b0);
    bad = -1;
    for (int i = 0; i <= FR; i++)
      if (smp[i] !== model_sout(8'h81, i)) begin
        bad = i;
        break;
      end
    tests++;
    if (bad >= 0 || rx_decode() !== 8'h81) begin
      fails++;
      $display("FAIL chg_frame: rx=%h idx %0d, required 81 with no bad idx",
               rx_decode(), bad);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (SOut !== 1'b1 || bus.DataInReady !== 1'b1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL chg_idle: %0d busy cycles, required 0", bad);
    end
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    capture(0, 8'h3C, 1'b0);
    tests++;
    if (rx_decode() !== 8'h3C) begin
      fails++;
      $display("FAIL chg_next: rx=%h, required 3c", rx_decode());
    end
  endtask

  task automatic test_abort();
    bit         ok;
    int         bad;
    logic [7:0] d;
    d = 8'($urandom) & 8'hF7;
    @(negedge Clock);
    bus.DataIn      = d;
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    for (int i = 0; i < 45; i++) begin
      @(negedge Clock);
      bus.DataInValid = 1'b0;
    end
    tests++;
    if (SOut !== 1'b0) begin
      fails++;
      $display("FAIL abort_pre: SOut=%b, required 0", SOut);
    end
    #2 Reset_n = 1'b0;
    #1;
    tests++;
    if ({SOut, bus.DataInReady} !== 2'b11) begin
      fails++;
      $display("FAIL abort_async: SOut,rdy=%b%b, required 11",
               SOut, bus.DataInReady);
    end
    @(negedge Clock);
    Reset_n         = 1'b1;
    bus.DataIn      = 8'h5A;
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    capture(0, 8'h5A, 1'b0);
    bad = -1;
    for (int i = 0; i <= FR; i++)
      if (smp[i] !== model_sout(8'h5A, i) || rdy[i] !== (i == FR)) begin
        bad = i;
        break;
      end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL abort_next: idx %0d SOut=%b rdy=%b, required %b %b",
               bad, smp[bad], rdy[bad], model_sout(8'h5A, bad), bad == FR);
    end
  endtask

  task automatic test_ignored();
    bit         ok;
    int         bad;
    time        t1;
    logic [7:0] d;
    d = 8'($urandom);
    @(negedge Clock);
    bus.DataIn      = d;
    bus.DataInValid = 1'b1;
    start_frame(ok);
    if (!ok) return;
    t1 = t_acc;
    capture(95, 8'h11, 1'b1);
    bad = -1;
    for (int i = 0; i <= FR; i++)
      if (smp[i] !== model_sout(d, i) || rdy[i] !== (i == FR)) begin
        bad = i;
        break;
      end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL ign_stop: idx %0d SOut=%b rdy=%b, required %b %b",
               bad, smp[bad], rdy[bad], model_sout(d, bad), bad == FR);
    end
    start_frame(ok);
    if (!ok) return;
    tests++;
    if (t_acc - t1 !== 64'd1010) begin
      fails++;
      $display("FAIL ign_accept: got %0t, required 1010", t_acc - t1);
    end
    capture(0, 8'h11, 1'b0);
    tests++;
    if (rx_decode() !== 8'h11) begin
      fails++;
      $display("FAIL ign_rx: rx=%h, required 11", rx_decode());
    end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      if (SOut !== 1'b1 || bus.DataInReady !== 1'b1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL ign_once: %0d busy cycles, required 0", bad);
    end
  endtask

  task automatic test_random();
    bit         ok;
    int         bad;
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge Clock);
      d = 8'($urandom);
      bus.DataIn      = d;
      bus.DataInValid = 1'b1;
      start_frame(ok);
      if (!ok) return;
      capture($urandom_range(0, FR-1), 8'($urandom), 1'b0);
      bad = -1;
      for (int i = 0; i <= FR; i++)
        if (smp[i] !== model_sout(d, i) || rdy[i] !== (i == FR)) begin
          bad = i;
          break;
        end
      tests++;
      if (bad >= 0 || rx_decode() !== d) begin
        fails++;
        $display("FAIL rand_%0d: rx=%h bad idx %0d, required %h",
                 n, rx_decode(), bad, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_data_change();
    test_abort();
    test_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
